ace_snoop_resp: RTL and testbench

Snoop responder at the cache (master) end of an ACE interface. It accepts snoop requests on the AC channel, performs one line-state lookup, and returns a CRRESP on the CR channel, followed by cache-line data on the CD channel when data transfer is required. It then issues one line-state update (invalidate or downgrade) to the local cache. The block is the counterpart of the interconnect-side shareability decoder: the interconnect generates the snoops, and this block answers them.

---
 rtl/ace_snoop_resp_if.sv | 48 ++++
 rtl/ace_snoop_resp.sv | 136 +++++++++++++
 tb/tb_ace_snoop_resp.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ace_snoop_resp_if.sv
// Snoop-side bundle for ace_snoop_resp: AC/CR/CD channels plus the local
// cache lookup, line-read and line-state update ports.
interface ace_snoop_resp_if #(
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64,
   parameter int LineBeats = 4
);
   localparam int BeatW = (LineBeats > 1) ? $clog2(LineBeats) : 1;

   logic                 ac_valid_i;
   logic                 ac_ready_o;
   logic [AddrWidth-1:0] ac_addr_i;
   logic [3:0]           ac_snoop_i;
   logic                 lookup_req_o;
   logic [AddrWidth-1:0] lookup_addr_o;
   logic                 lookup_hit_i;
   logic                 lookup_dirty_i;
   logic                 lookup_unique_i;
   logic [BeatW-1:0]     line_rd_beat_o;
   logic [DataWidth-1:0] line_rd_data_i;
   logic                 cr_valid_o;
   logic                 cr_ready_i;
   logic [4:0]           cr_resp_o;
   logic                 cd_valid_o;
   logic                 cd_ready_i;
   logic [DataWidth-1:0] cd_data_o;
   logic                 cd_last_o;
   logic                 upd_valid_o;
   logic                 upd_inval_o;

   modport slave (
      input  ac_valid_i, ac_addr_i, ac_snoop_i,
      input  lookup_hit_i, lookup_dirty_i, lookup_unique_i, line_rd_data_i,
      input  cr_ready_i, cd_ready_i,
      output ac_ready_o, lookup_req_o, lookup_addr_o, line_rd_beat_o,
      output cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
      output upd_valid_o, upd_inval_o
   );

   modport master (
      output ac_valid_i, ac_addr_i, ac_snoop_i,
      output lookup_hit_i, lookup_dirty_i, lookup_unique_i, line_rd_data_i,
      output cr_ready_i, cd_ready_i,
      input  ac_ready_o, lookup_req_o, lookup_addr_o, line_rd_beat_o,
      input  cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
      input  upd_valid_o, upd_inval_o
   );
endinterface

// File: rtl/ace_snoop_resp.sv
// ACE snoop responder: AC snoop -> lookup -> CRRESP -> optional CD line -> line-state update.
// Optional macro ACE_SNOOP_RESP_DVM_EN: acknowledge DVM snoops (1110/1111) instead of erroring.
module ace_snoop_resp #(
   parameter int AddrWidth = 64,
   parameter int DataWidth = 64,
   parameter int LineBeats = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   ace_snoop_resp_if.slave bus
);
   localparam int BeatW = (LineBeats > 1) ? $clog2(LineBeats) : 1;
   localparam logic [BeatW-1:0] LastBeat = BeatW'(LineBeats - 1);

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RESP, S_DATA, S_UPDATE} state_e;

   // resp bit order: {WasUnique, IsShared, PassDirty, Error, DataTransfer}
   typedef struct packed {
      logic [4:0] resp;
      logic       upd;
      logic       inval;
   } action_t;

   function automatic action_t decode(input logic [3:0] snoop, input logic hit,
                                      input logic dirty, input logic uniq);
      action_t a;
      a = '0;
      case (snoop)
         4'b0000: if (hit) a.resp = {uniq, 1'b1, 1'b0, 1'b0, 1'b1};
         4'b0001, 4'b0010, 4'b0011: if (hit) begin
            a.resp = {uniq, 1'b1, dirty, 1'b0, 1'b1};
            a.upd  = 1'b1;
         end
         4'b0111: if (hit) begin
            a.resp  = {uniq, 1'b0, dirty, 1'b0, 1'b1};
            a.upd   = 1'b1;
            a.inval = 1'b1;
         end
         4'b1000: if (hit) begin
            a.resp = {uniq, 1'b1, dirty, 1'b0, dirty};
            a.upd  = 1'b1;
         end
         4'b1001: if (hit) begin
            a.resp  = {uniq, 1'b0, dirty, 1'b0, dirty};
            a.upd   = 1'b1;
            a.inval = 1'b1;
         end
         4'b1101: if (hit) begin
            a.resp  = {uniq, 4'b0000};
            a.upd   = 1'b1;
            a.inval = 1'b1;
         end
`ifdef ACE_SNOOP_RESP_DVM_EN
         4'b1110, 4'b1111: a = '0;
`endif
         default: a.resp = 5'b00010;
      endcase
      return a;
   endfunction

   state_e               r_state, w_next;
   logic [AddrWidth-1:0] r_addr;
   logic [3:0]           r_snoop;
   action_t              r_act;
   logic [BeatW-1:0]     r_beat;
   logic [DataWidth-1:0] w_cd_data;
   logic                 w_ac_ready, w_lookup, w_cr_valid, w_cd_valid, w_upd, w_last;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // Counter wraps explicitly so LineBeats=1 (single-bit counter) still returns to 0.
   always_ff @(posedge clk_i) begin
      if (!rst_ni)                        r_beat <= '0;
      else if (w_cd_valid && bus.cd_ready_i) r_beat <= w_last ? '0 : r_beat + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (w_ac_ready && bus.ac_valid_i) begin
         r_addr  <= bus.ac_addr_i;
         r_snoop <= bus.ac_snoop_i;
      end
      if (r_state == S_LOOKUP)
         r_act <= decode(r_snoop, bus.lookup_hit_i, bus.lookup_dirty_i, bus.lookup_unique_i);
   end

   assign w_last = (r_state == S_DATA) && (r_beat == LastBeat);

   always_comb begin
      w_next     = r_state;
      w_ac_ready = 1'b0;
      w_lookup   = 1'b0;
      w_cr_valid = 1'b0;
      w_cd_valid = 1'b0;
      w_upd      = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ac_ready = 1'b1;
            if (bus.ac_valid_i) w_next = S_LOOKUP;
         end
         S_LOOKUP: begin
            w_lookup = 1'b1;
            w_next   = S_RESP;
         end
         S_RESP: begin
            w_cr_valid = 1'b1;
            if (bus.cr_ready_i)
               w_next = r_act.resp[0] ? S_DATA : (r_act.upd ? S_UPDATE : S_IDLE);
         end
         S_DATA: begin
            w_cd_valid = 1'b1;
            if (bus.cd_ready_i && w_last) w_next = r_act.upd ? S_UPDATE : S_IDLE;
         end
         S_UPDATE: begin
            w_upd  = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_cd_data          = bus.line_rd_data_i;
   assign bus.ac_ready_o     = w_ac_ready;
   assign bus.lookup_req_o   = w_lookup;
   assign bus.lookup_addr_o  = r_addr;
   assign bus.line_rd_beat_o = r_beat;
   assign bus.cr_valid_o     = w_cr_valid;
   assign bus.cr_resp_o      = w_cr_valid ? r_act.resp : 5'b00000;
   assign bus.cd_valid_o     = w_cd_valid;
   assign bus.cd_data_o      = w_cd_data;
   assign bus.cd_last_o      = w_last;
   assign bus.upd_valid_o    = w_upd;
   assign bus.upd_inval_o    = w_upd & r_act.inval;
endmodule

// File: tb/tb_ace_snoop_resp.sv
// Testbench for ace_snoop_resp: directed and randomized snoops checked against
// a rule-level response model.
module tb_ace_snoop_resp;
   localparam int AW = 64;
   localparam int DW = 64;
   localparam int LB = 4;

   typedef struct packed {
      logic [4:0] resp;
      logic [7:0] nbeats;
      logic       upd;
      logic       inval;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ace_snoop_resp_if #(.AddrWidth(AW), .DataWidth(DW), .LineBeats(LB)) bus();
   ace_snoop_resp #(.AddrWidth(AW), .DataWidth(DW), .LineBeats(LB)) dut (
      .clk_i (clk),
      .rst_ni(rst_n),
      .bus   (bus)
   );

   logic [DW-1:0] line_data [LB];
   assign bus.line_rd_data_i = line_data[bus.line_rd_beat_o];

   int n_checks = 0;
   int n_errors = 0;

   // Observations of one transaction
   int            ob_lookup_n, ob_lookup_cyc, ob_cr_n, ob_cr_cyc;
   int            ob_cd_first, ob_cd_last_cyc, ob_upd_n, ob_upd_cyc, ob_end_cyc;
   logic [AW-1:0] ob_lookup_addr;
   logic [4:0]    ob_resp;
   bit            ob_resp_unstable, ob_hold_bad, ob_timeout, ob_upd_inval;
   logic [DW-1:0] ob_beats[$];
   bit            ob_lasts[$];

   // Reference model written directly from the snoop response rules.
   function automatic exp_t model(input int sn, input bit hit, input bit dirty, input bit uq);
      exp_t e;
      bit dt, pd, is_sh;
      e = '0;
`ifdef ACE_SNOOP_RESP_DVM_EN
      if (sn == 14 || sn == 15) return e;
`endif
      if (!(sn inside {0, 1, 2, 3, 7, 8, 9, 13})) begin
         e.resp = 5'b00010;
         return e;
      end
      if (!hit) return e;
      dt       = (sn <= 7) ? 1'b1 : ((sn == 13) ? 1'b0 : dirty);
      pd       = (sn == 0 || sn == 13) ? 1'b0 : dirty;
      is_sh    = (sn inside {0, 1, 2, 3, 8});
      e.resp   = {uq, is_sh, pd, 1'b0, dt};
      e.nbeats = dt ? 8'(LB) : 8'd0;
      e.upd    = (sn != 0);
      e.inval  = (sn inside {7, 9, 13});
      return e;
   endfunction

   // Drives one snoop and records what the DUT does until it is idle again.
   // cd_mode: 0 = always ready, 1 = ready on even cycles, 2 = random.
   task automatic do_snoop(input logic [3:0] sn, input logic [AW-1:0] addr, input bit hit,
                           input bit dirty, input bit uq, input int cr_stall, input int cd_mode);
      int k, crw;
      bit pend, rdy, pl;
      logic [DW-1:0] pdat;
      ob_lookup_n = 0; ob_lookup_cyc = -1; ob_cr_n = 0; ob_cr_cyc = -1;
      ob_cd_first = -1; ob_cd_last_cyc = -1; ob_upd_n = 0; ob_upd_cyc = -1; ob_end_cyc = -1;
      ob_lookup_addr = '0; ob_resp = '0; ob_resp_unstable = 0; ob_hold_bad = 0;
      ob_timeout = 0; ob_upd_inval = 0;
      ob_beats.delete(); ob_lasts.delete();
      @(negedge clk);
      for (int b = 0; b < LB; b++) line_data[b] = {$urandom, $urandom};
      bus.lookup_hit_i = hit; bus.lookup_dirty_i = dirty; bus.lookup_unique_i = uq;
      bus.ac_addr_i = addr; bus.ac_snoop_i = sn; bus.ac_valid_i = 1'b1;
      k = 0;
      while (bus.ac_ready_o !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      if (k >= 20) ob_timeout = 1;
      k = 0; crw = 0; pend = 0; pl = 0; pdat = '0;
      while (1) begin
         @(negedge clk);
         k++;
         bus.ac_valid_i = 1'b0;
         if (bus.ac_ready_o === 1'b1) begin ob_end_cyc = k; break; end
         if (bus.lookup_req_o === 1'b1) begin
            ob_lookup_n++; ob_lookup_cyc = k; ob_lookup_addr = bus.lookup_addr_o;
         end
         if (bus.cr_valid_o === 1'b1) begin
            if (ob_cr_n == 0) begin ob_cr_cyc = k; ob_resp = bus.cr_resp_o; end
            else if (bus.cr_resp_o !== ob_resp) ob_resp_unstable = 1;
            ob_cr_n++;
            bus.cr_ready_i = (crw >= cr_stall);
            crw++;
         end else bus.cr_ready_i = 1'b0;
         if (bus.cd_valid_o === 1'b1) begin
            if (pend && (bus.cd_data_o !== pdat || bus.cd_last_o !== pl)) ob_hold_bad = 1;
            rdy = (cd_mode == 0) ? 1'b1 : (cd_mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
            bus.cd_ready_i = rdy;
            if (rdy) begin
               ob_beats.push_back(bus.cd_data_o);
               ob_lasts.push_back(bus.cd_last_o);
               if (ob_cd_first < 0) ob_cd_first = k;
               ob_cd_last_cyc = k;
               pend = 0;
            end else begin
               pend = 1; pdat = bus.cd_data_o; pl = bus.cd_last_o;
            end
         end else begin
            bus.cd_ready_i = 1'b0;
            if (pend) ob_hold_bad = 1;
         end
         if (bus.upd_valid_o === 1'b1) begin
            ob_upd_n++; ob_upd_cyc = k; ob_upd_inval = bus.upd_inval_o;
         end
         if (k >= 300) begin ob_timeout = 1; break; end
      end
      bus.cr_ready_i = 1'b0;
      bus.cd_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (bus.ac_ready_o !== 1'b1) begin n_errors++; $display("FAIL reset_ac_ready: got %b want 1", bus.ac_ready_o); end
      n_checks++; if (bus.lookup_req_o !== 1'b0) begin n_errors++; $display("FAIL reset_lookup: got %b want 0", bus.lookup_req_o); end
      n_checks++; if ({bus.cr_valid_o, bus.cr_resp_o} !== 6'd0) begin n_errors++; $display("FAIL reset_cr: got %b want 0", {bus.cr_valid_o, bus.cr_resp_o}); end
      n_checks++; if ({bus.cd_valid_o, bus.cd_last_o} !== 2'd0) begin n_errors++; $display("FAIL reset_cd: got %b want 0", {bus.cd_valid_o, bus.cd_last_o}); end
      n_checks++; if ({bus.upd_valid_o, bus.upd_inval_o} !== 2'd0) begin n_errors++; $display("FAIL reset_upd: got %b want 0", {bus.upd_valid_o, bus.upd_inval_o}); end
      n_checks++; if (bus.line_rd_beat_o !== '0) begin n_errors++; $display("FAIL reset_beat: got %0d want 0", bus.line_rd_beat_o); end
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (bus.ac_ready_o !== 1'b1) begin n_errors++; $display("FAIL post_reset_idle: got %b want 1", bus.ac_ready_o); end
   endtask

   task automatic test_read_shared();
      exp_t e;
      bit bad;
      e = model(1, 1, 1, 1);
      do_snoop(4'b0001, 64'h0000_1234_5678_9AC0, 1, 1, 1, 0, 0);
      n_checks++; if (ob_timeout !== 0) begin n_errors++; $display("FAIL rs_timeout: got %b want 0", ob_timeout); end
      n_checks++; if (ob_lookup_n != 1 || ob_lookup_cyc != 1) begin n_errors++; $display("FAIL rs_lookup: got n=%0d cyc=%0d want n=1 cyc=1", ob_lookup_n, ob_lookup_cyc); end
      n_checks++; if (ob_lookup_addr !== 64'h0000_1234_5678_9AC0) begin n_errors++; $display("FAIL rs_lookup_addr: got %h want %h", ob_lookup_addr, 64'h0000_1234_5678_9AC0); end
      n_checks++; if (ob_cr_cyc != 2) begin n_errors++; $display("FAIL rs_cr_cycle: got %0d want 2", ob_cr_cyc); end
      n_checks++; if (ob_resp !== e.resp) begin n_errors++; $display("FAIL rs_resp: got %b want %b", ob_resp, e.resp); end
      n_checks++; if (ob_cd_first != 3 || ob_cd_last_cyc != 3 + LB - 1) begin n_errors++; $display("FAIL rs_cd_timing: got %0d..%0d want 3..%0d", ob_cd_first, ob_cd_last_cyc, 3 + LB - 1); end
      bad = (ob_beats.size() != int'(e.nbeats));
      foreach (ob_beats[i]) if (ob_beats[i] !== line_data[i] || ob_lasts[i] != (i == LB - 1)) bad = 1;
      n_checks++; if (bad) begin n_errors++; $display("FAIL rs_beats: got %0d beats want %0d with matching data/last", ob_beats.size(), e.nbeats); end
      n_checks++; if (ob_upd_n != 1 || ob_upd_cyc != ob_cd_last_cyc + 1) begin n_errors++; $display("FAIL rs_upd: got n=%0d cyc=%0d want n=1 cyc=%0d", ob_upd_n, ob_upd_cyc, ob_cd_last_cyc + 1); end
      n_checks++; if (ob_upd_inval !== e.inval) begin n_errors++; $display("FAIL rs_upd_inval: got %b want %b", ob_upd_inval, e.inval); end
   endtask

   task automatic test_read_unique_backpressure();
      exp_t e;
      bit bad;
      e = model(7, 1, 0, 0);
      do_snoop(4'b0111, 64'h0000_0000_0000_8000, 1, 0, 0, 0, 1);
      n_checks++; if (ob_resp !== e.resp) begin n_errors++; $display("FAIL ru_resp: got %b want %b", ob_resp, e.resp); end
      bad = (ob_beats.size() != int'(e.nbeats));
      foreach (ob_beats[i]) if (ob_beats[i] !== line_data[i] || ob_lasts[i] != (i == LB - 1)) bad = 1;
      n_checks++; if (bad) begin n_errors++; $display("FAIL ru_beats: got %0d beats want %0d in order", ob_beats.size(), e.nbeats); end
      n_checks++; if (ob_hold_bad !== 0) begin n_errors++; $display("FAIL ru_hold: got unstable=%b want 0", ob_hold_bad); end
      n_checks++; if (ob_upd_n != 1 || ob_upd_inval !== 1'b1) begin n_errors++; $display("FAIL ru_upd: got n=%0d inval=%b want n=1 inval=1", ob_upd_n, ob_upd_inval); end
      n_checks++; if (ob_upd_cyc != ob_cd_last_cyc + 1) begin n_errors++; $display("FAIL ru_upd_cycle: got %0d want %0d", ob_upd_cyc, ob_cd_last_cyc + 1); end
   endtask

   task automatic test_clean_invalid_and_misses();
      exp_t e;
      e = model(9, 1, 0, 1);
      do_snoop(4'b1001, 64'h40, 1, 0, 1, 0, 0);
      n_checks++; if (ob_resp !== e.resp) begin n_errors++; $display("FAIL ci_resp: got %b want %b", ob_resp, e.resp); end
      n_checks++; if (ob_beats.size() != 0) begin n_errors++; $display("FAIL ci_no_cd: got %0d beats want 0", ob_beats.size()); end
      n_checks++; if (ob_upd_n != 1 || ob_upd_inval !== 1'b1 || ob_upd_cyc != 3) begin n_errors++; $display("FAIL ci_upd: got n=%0d inval=%b cyc=%0d want 1/1/3", ob_upd_n, ob_upd_inval, ob_upd_cyc); end
      n_checks++; if (ob_end_cyc != 4) begin n_errors++; $display("FAIL ci_idle_cycle: got %0d want 4", ob_end_cyc); end
      for (int s = 0; s < 16; s++) begin
         e = model(s, 0, 1, 1);
         do_snoop(4'(s), 64'(s) << 6, 0, 1, 1, 0, 0);
         n_checks++;
         if (ob_resp !== e.resp || ob_beats.size() != 0 || ob_upd_n != 0 || ob_timeout) begin
            n_errors++;
            $display("FAIL miss_%0d: got resp=%b beats=%0d upd=%0d want resp=%b beats=0 upd=0", s, ob_resp, ob_beats.size(), ob_upd_n, e.resp);
         end
      end
   endtask

   task automatic test_dvm();
      exp_t e;
      for (int s = 14; s < 16; s++) begin
         e = model(s, 1, 1, 1);
         do_snoop(4'(s), 64'h80, 1, 1, 1, 0, 0);
         n_checks++;
         if (ob_resp !== e.resp || ob_beats.size() != 0 || ob_upd_n != 0) begin
            n_errors++;
            $display("FAIL dvm_%0d: got resp=%b beats=%0d upd=%0d want resp=%b beats=0 upd=0", s, ob_resp, ob_beats.size(), ob_upd_n, e.resp);
         end
      end
   endtask

   task automatic test_stall_and_reset();
      exp_t e;
      bit bad;
      e = model(1, 1, 1, 0);
      @(negedge clk);
      for (int b = 0; b < LB; b++) line_data[b] = {$urandom, $urandom};
      bus.lookup_hit_i = 1; bus.lookup_dirty_i = 1; bus.lookup_unique_i = 0;
      bus.ac_addr_i = 64'h1C0; bus.ac_snoop_i = 4'b0001; bus.ac_valid_i = 1;
      @(negedge clk);
      bus.ac_valid_i = 0;
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.cr_valid_o !== 1'b1 || bus.cr_resp_o !== e.resp || bus.ac_ready_o !== 1'b0) bad = 1;
         @(negedge clk);
      end
      n_checks++; if (bad) begin n_errors++; $display("FAIL stall_hold: got unstable CR or ac_ready high want stable resp %b", e.resp); end
      n_checks++; if (bus.cr_resp_o !== e.resp) begin n_errors++; $display("FAIL stall_resp: got %b want %b", bus.cr_resp_o, e.resp); end
      bus.cr_ready_i = 1;
      @(negedge clk);
      bus.cr_ready_i = 0; bus.cd_ready_i = 1;
      n_checks++; if (bus.cd_valid_o !== 1'b1 || bus.line_rd_beat_o !== 2'd0) begin n_errors++; $display("FAIL stall_beat0: got valid=%b beat=%0d want 1/0", bus.cd_valid_o, bus.line_rd_beat_o); end
      repeat (2) @(negedge clk);
      n_checks++; if (bus.line_rd_beat_o !== 2'd2) begin n_errors++; $display("FAIL stall_beat2: got %0d want 2", bus.line_rd_beat_o); end
      rst_n = 0;
      @(negedge clk);
      bus.cd_ready_i = 0;
      n_checks++;
      if (bus.ac_ready_o !== 1'b1 || bus.lookup_req_o !== 1'b0 || bus.cr_valid_o !== 1'b0 || bus.cr_resp_o !== 5'd0 ||
          bus.cd_valid_o !== 1'b0 || bus.cd_last_o !== 1'b0 || bus.upd_valid_o !== 1'b0 || bus.upd_inval_o !== 1'b0 ||
          bus.line_rd_beat_o !== 2'd0) begin
         n_errors++;
         $display("FAIL abort_reset: got rdy=%b lk=%b crv=%b resp=%b cdv=%b last=%b upd=%b inv=%b beat=%0d want reset values",
                  bus.ac_ready_o, bus.lookup_req_o, bus.cr_valid_o, bus.cr_resp_o, bus.cd_valid_o, bus.cd_last_o,
                  bus.upd_valid_o, bus.upd_inval_o, bus.line_rd_beat_o);
      end
      rst_n = 1;
      bad = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.upd_valid_o !== 1'b0 || bus.cd_valid_o !== 1'b0) bad = 1;
      end
      n_checks++; if (bad) begin n_errors++; $display("FAIL abort_no_upd: got update or beat after reset want none"); end
   endtask

   task automatic test_random();
      exp_t e;
      bit bad, hit, dirty, uq;
      int sn, stall;
      for (int it = 0; it < 40; it++) begin
         sn = $urandom_range(0, 15);
         hit = 1'($urandom_range(0, 3) != 0);
         dirty = 1'($urandom_range(0, 1));
         uq = 1'($urandom_range(0, 1));
         stall = $urandom_range(0, 3);
         e = model(sn, hit, dirty, uq);
         do_snoop(4'(sn), {$urandom, $urandom}, hit, dirty, uq, stall, 2);
         bad = (ob_beats.size() != int'(e.nbeats));
         foreach (ob_beats[i]) if (ob_beats[i] !== line_data[i] || ob_lasts[i] != (i == LB - 1)) bad = 1;
         n_checks++;
         if (ob_timeout || ob_resp !== e.resp || ob_resp_unstable || ob_cr_n != stall + 1) begin
            n_errors++;
            $display("FAIL rnd_cr_%0d: snoop=%0d got resp=%b cr_cycles=%0d want resp=%b cr_cycles=%0d", it, sn, ob_resp, ob_cr_n, e.resp, stall + 1);
         end
         n_checks++;
         if (bad || ob_hold_bad) begin
            n_errors++;
            $display("FAIL rnd_cd_%0d: snoop=%0d got %0d beats hold_bad=%b want %0d beats", it, sn, ob_beats.size(), ob_hold_bad, e.nbeats);
         end
         n_checks++;
         if (ob_upd_n != int'(e.upd) || (e.upd && ob_upd_inval !== e.inval) ||
             (e.upd && e.nbeats != 0 && ob_upd_cyc != ob_cd_last_cyc + 1)) begin
            n_errors++;
            $display("FAIL rnd_upd_%0d: snoop=%0d got n=%0d inval=%b cyc=%0d want n=%0d inval=%b", it, sn, ob_upd_n, ob_upd_inval, ob_upd_cyc, e.upd, e.inval);
         end
      end
   endtask

   initial begin
      bus.ac_valid_i = 0; bus.ac_addr_i = '0; bus.ac_snoop_i = '0;
      bus.lookup_hit_i = 0; bus.lookup_dirty_i = 0; bus.lookup_unique_i = 0;
      bus.cr_ready_i = 0; bus.cd_ready_i = 0;
      for (int b = 0; b < LB; b++) line_data[b] = '0;
      test_reset();
      test_read_shared();
      test_read_unique_backpressure();
      test_clean_invalid_and_misses();
      test_dvm();
      test_stall_and_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end
endmodule
